// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and helpers for the mux scan controller: channel codes,
// FSM state encoding and the channel-to-select mapping for the 3-to-1 mux.
package mux_scan_ctrl_pkg;

    localparam int unsigned CH_BITS = 2;
    localparam int unsigned FRAME_W = 3;

    typedef logic [CH_BITS-1:0] ch_t;

    localparam ch_t CH_U = 2'd0;
    localparam ch_t CH_V = 2'd1;
    localparam ch_t CH_W = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    typedef struct packed {
        logic s1;
        logic s0;
    } sel_t;

    // s0 only distinguishes u from v; it is held low while w is selected
    function automatic sel_t sel_of_ch(input ch_t ch);
        sel_t sel;
        sel = '0;
        case (ch)
            CH_V:    sel.s0 = 1'b1;
            CH_W:    sel.s1 = 1'b1;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control, select and sample signals between the scan controller and its
// environment (the 3-to-1 mux and whatever consumes the frames).
interface mux_scan_ctrl_if
    import mux_scan_ctrl_pkg::*;
();

    logic               start;
    logic               stop;
    logic               cont;
    logic               m;
    logic               s0;
    logic               s1;
    ch_t                ch;
    logic [FRAME_W-1:0] sample;
    logic               sample_valid;
    logic               busy;

    modport master (
        output start, stop, cont, m,
        input  s0, s1, ch, sample, sample_valid, busy
    );

    modport slave (
        input  start, stop, cont, m,
        output s0, s1, ch, sample, sample_valid, busy
    );

endinterface

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Dwell counter: counts enabled cycles and flags the last cycle of each dwell,
// wrapping to zero on that cycle.
module dwell_counter #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic term_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign term_c_o = (cnt_q == CNT_W'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = term_c_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans mux channels u, v, w with a programmable dwell, captures the mux output
// at the end of each dwell and publishes the three bits as one frame.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_scan_ctrl_if.slave   bus_io
);

    state_e             state_q, state_d;
    ch_t                ch_q, ch_d;
    sel_t               sel_q, sel_d;
    logic [1:0]         shadow_q, shadow_d;
    logic [FRAME_W-1:0] sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               cont_q, cont_d;
    logic               cnt_en_c;
    logic               term_c;

    // Counter only runs while scanning; it is held at zero otherwise
    assign cnt_en_c = (state_q == ST_SCAN) && !bus_io.stop;

    dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!cnt_en_c),
        .en_i     (cnt_en_c),
        .term_c_o (term_c)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        cont_d   = cont_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_io.start && !bus_io.stop) begin
                    state_d = ST_SCAN;
                    ch_d    = CH_U;
                    busy_d  = 1'b1;
                    cont_d  = bus_io.cont;
                end
            end
            ST_SCAN: begin
                if (bus_io.stop) begin
                    state_d = ST_IDLE;
                    ch_d    = CH_U;
                    busy_d  = 1'b0;
                end else if (term_c) begin
                    if (ch_q != CH_W) begin
                        shadow_d[ch_q[0]] = bus_io.m;
                        ch_d              = ch_q + 2'd1;
                    end else begin
                        // w is taken straight from m so the frame completes on this edge
                        sample_d = {bus_io.m, shadow_q};
                        valid_d  = 1'b1;
                        ch_d     = CH_U;
                        if (!cont_q) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sel_d = sel_of_ch(ch_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= CH_U;
            sel_q    <= '0;
            shadow_q <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            cont_q   <= cont_d;
        end
    end

    assign bus_io.s0           = sel_q.s0;
    assign bus_io.s1           = sel_q.s1;
    assign bus_io.ch           = ch_q;
    assign bus_io.sample       = sample_q;
    assign bus_io.sample_valid = valid_q;
    assign bus_io.busy         = busy_q;

endmodule
